// File: rtl/spectrum_bar_scaler.sv
// Scales every spectrum bin to a bar height floor(bin*BAR_MAX/peak) with a serial restoring divider.
// Optional build macro: SCALER_DC_SKIP_EN (bin 0 forced to height 0 without being read).
module spectrum_bar_scaler #(
  parameter int N_BINS     = 512,
  parameter int BAR_MAX    = 479,
  parameter int QW         = 9,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          max_found_i,
  input  logic [63:0]   max_value_i,
  output logic [9:0]    read_buff_add_o,
  input  logic [63:0]   buffer_data_i,
  output logic          bar_we_o,
  output logic [9:0]    bar_add_o,
  output logic [QW-1:0] bar_height_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int NW = 64 + QW;
  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT_RD = 3'd2,
    DIV     = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_q;
  logic [63:0]     peak_q;
  logic [9:0]      bin_q;
  logic [CW-1:0]   cnt_q;
  logic [NW-1:0]   rem_q;
  logic [NW-1:0]   dsr_q;
  logic [QW-1:0]   quot_q;
  logic [9:0]      read_add_q;
  logic            bar_we_q;
  logic [9:0]      bar_add_q;
  logic [QW-1:0]   bar_height_q;
  logic            busy_q;
  logic            done_q;
  logic            ge_s;

  assign ge_s = (rem_q >= dsr_q);

  assign read_buff_add_o = read_add_q;
  assign bar_we_o        = bar_we_q;
  assign bar_add_o       = bar_add_q;
  assign bar_height_o    = bar_height_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  // Frame sequencer, divider datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      peak_q       <= 64'd0;
      bin_q        <= 10'd0;
      cnt_q        <= '0;
      rem_q        <= '0;
      dsr_q        <= '0;
      quot_q       <= '0;
      read_add_q   <= 10'd0;
      bar_we_q     <= 1'b0;
      bar_add_q    <= 10'd0;
      bar_height_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      bar_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // a pulse coinciding with done_o belongs to the frame just finished
          if (max_found_i && !done_q) begin
            peak_q <= max_value_i;
            bin_q  <= 10'd0;
            busy_q <= 1'b1;
`ifdef SCALER_DC_SKIP_EN
            quot_q  <= '0;
            state_q <= WRITE;
`else
            state_q <= ADDR;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          read_add_q <= bin_q;
          cnt_q      <= '0;
          state_q    <= WAIT_RD;
        end
        WAIT_RD: begin
          if (cnt_q == CW'(RD_LATENCY - 1)) begin
            rem_q <= NW'(buffer_data_i) * NW'(BAR_MAX);
            dsr_q <= NW'(peak_q) << (QW - 1);
            cnt_q <= '0;
            if (buffer_data_i >= peak_q) begin
              quot_q  <= QW'(BAR_MAX);
              state_q <= WRITE;
            end else begin
              quot_q  <= '0;
              state_q <= DIV;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DIV: begin
          // one quotient bit per cycle, MSB first
          if (ge_s) begin
            rem_q <= rem_q - dsr_q;
          end else begin
            rem_q <= rem_q;
          end
          quot_q <= {quot_q[QW-2:0], ge_s};
          dsr_q  <= dsr_q >> 1;
          if (cnt_q == CW'(QW - 1)) begin
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WRITE: begin
          bar_we_q     <= 1'b1;
          bar_add_q    <= bin_q;
          bar_height_q <= quot_q;
          if (bin_q == 10'(N_BINS - 1)) begin
            state_q <= DONE;
          end else begin
            bin_q   <= bin_q + 10'd1;
            state_q <= ADDR;
          end
        end
        DONE: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          read_add_q <= 10'd0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
